set_job_dispatcher: RTL and testbench
=====================================

Name: set_job_dispatcher

Overview:
- Upstream/downstream wrapper stage for the circle-intersection core (module SET).
- Accepts intersection jobs (central, radius) over a valid/ready stream and buffers them in a small FIFO.
- Issues jobs one at a time to SET via its en/central/radius interface, then captures SET's candidate count on its valid pulse.
- Returns each count with a sequential tag over a valid/ready result stream.

Parameters:
- DEPTH, 4, job FIFO entries; power of two, 2..16.
- TAG_W, 4, result tag width; tag counter wraps modulo 2^TAG_W.
- TMO_CYC, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- job_valid  in  1  job offered.
- job_ready  out  1  FIFO not full.
- job_central  in  16  {x1,y1,x2,y2}, 4 bits each.
- job_radius  in  8  {r1,r2}, 4 bits each.
- set_en  out  1  one-cycle start pulse to SET.
- set_central  out  16  to SET central.
- set_radius  out  8  to SET radius.
- set_busy  in  1  SET busy.
- set_valid  in  1  SET one-cycle result pulse.
- set_candidate  in  8  SET result, sampled when set_valid=1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_candidate  out  8  captured count.
- res_tag  out  TAG_W  job sequence number, starts at 0.
- idle  out  1  FIFO empty, FSM in IDLE, no result pending.
- err_timeout  out  1  sticky watchdog flag; tied to 0 without the macro.

Behaviour:
- Reset values (rst=0):
  - All outputs 0 except idle=1 and job_ready=1.
  - FIFO empty, tag counter 0, FSM in IDLE.
- Job FIFO:
  - Push when job_valid & job_ready; pop on ISSUE.
  - job_ready = !full (registered count).
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push while full is ignored.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE -> ISSUE when FIFO non-empty and res_valid=0. Only one job is in flight, and the result register must be free.
  - ISSUE (1 cycle): set_en=1; set_central/set_radius driven from the FIFO head, registered so they are stable in the en cycle; pop the FIFO. -> WAIT.
  - WAIT: hold set_en=0.
    - On set_valid=1: capture set_candidate into res_candidate, res_tag=tag counter, res_valid<=1, tag counter increments (wraps). -> IDLE.
    - set_valid may arrive any cycle after ISSUE, including the cycle directly after ISSUE (SET's early-exit path). set_busy is not required to rise first.
- set_en never asserts while in WAIT or while set_busy=1. set_busy=1 in IDLE defers the transition to ISSUE.
- set_valid outside WAIT is ignored; no capture, no tag increment.
- Result handshake:
  - res_valid holds, with stable res_candidate/res_tag, until res_valid & res_ready; it clears the next edge.
  - A capture and a consume in the same cycle cannot occur, because a capture requires res_valid=0 at issue.
- idle = (count==0) & (state==IDLE) & !res_valid.
- Reset mid-operation: all state cleared asynchronously. Queued jobs are lost. The SET core is reset by the same net.
- Widths: candidate is passed through unmodified, 8 bits, max 64.

Optional Feature:
- Macro SET_DISP_TIMEOUT_EN.
- Defined:
  - 8-bit watchdog counts cycles in WAIT.
  - On reaching TMO_CYC without set_valid: res_candidate=8'hFF, res_valid=1, tag increments, err_timeout<=1 (sticky until reset). -> IDLE.
- Undefined:
  - No counter; WAIT lasts indefinitely; err_timeout is a constant 0.

Decomposition:
- Shared package set_pkg:
  - FSM state encoding (IDLE, ISSUE, WAIT).
  - Field widths: COORD_W=4, CENT_W=16, RAD_W=8, CAND_W=8.
  - Timeout code CAND_TMO=8'hFF.
- One sub-module: set_job_fifo (parameterised DEPTH, data width 24, synchronous push/pop, full/empty/count, same async active-low rst).

Test Plan:
- Single job: central=16'h4455, radius=8'h33, behavioural SET model returns candidate=8'd13 after 40 cycles -> one set_en pulse with those values; res_valid=1, res_candidate=13, res_tag=0.
- Back-to-back: 5 jobs pushed with DEPTH=4 -> job_ready=0 after the fourth accepted push until the first pop; exactly one set_en per job; tags 0..4 in order.
- Result backpressure: res_ready=0 for 20 cycles after the first result -> second job not issued (set_en stays 0) until the first result is consumed.
- Early exit: SET model pulses set_valid one cycle after set_en with candidate=0 -> captured as 0, FSM returns to IDLE.
- Tag wrap: 17 jobs with TAG_W=4 -> the seventeenth result has res_tag=0. Also assert rst=0 mid-WAIT -> all outputs return to reset values, FIFO empty, idle=1.
- With SET_DISP_TIMEOUT_EN, TMO_CYC=10, SET model never responds -> res_candidate=8'hFF, err_timeout=1, dispatcher proceeds to the next job.

Source files
------------

// File: rtl/set_pkg.sv
// Shared types and widths for the SET job dispatcher.
// The optional watchdog is enabled by defining SET_DISP_TIMEOUT_EN.
package set_pkg;

  localparam int unsigned COORD_W = 4;
  localparam int unsigned CENT_W  = 4 * COORD_W;
  localparam int unsigned RAD_W   = 2 * COORD_W;
  localparam int unsigned CAND_W  = 8;
  localparam int unsigned WDOG_W  = 8;

  localparam logic [CAND_W-1:0] CAND_TMO = 8'hFF;

  // Dispatcher FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } disp_state_e;

  // One queued job: central {x1,y1,x2,y2}, radius {r1,r2}
  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] r1;
    logic [COORD_W-1:0] r2;
  } set_job_t;

  localparam int unsigned JOB_W = $bits(set_job_t);

endpackage

// File: rtl/set_job_fifo.sv
// Small synchronous job FIFO; DEPTH must be a power of two so pointers wrap naturally.
module set_job_fifo
  import set_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = JOB_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == CNT_W'(0));
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage array, written on accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/set_job_dispatcher.sv
// Buffers circle-intersection jobs, issues them one at a time to SET and
// returns each candidate count with a sequence tag.
// Optional watchdog on the SET response: define SET_DISP_TIMEOUT_EN.
module set_job_dispatcher
  import set_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [CENT_W-1:0] job_central,
  input  logic [RAD_W-1:0]  job_radius,
  output logic              set_en,
  output logic [CENT_W-1:0] set_central,
  output logic [RAD_W-1:0]  set_radius,
  input  logic              set_busy,
  input  logic              set_valid,
  input  logic [CAND_W-1:0] set_candidate,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CAND_W-1:0] res_candidate,
  output logic [TAG_W-1:0]  res_tag,
  output logic              idle,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  disp_state_e      r_state;
  logic [TAG_W-1:0] r_tag;
  set_job_t         w_job_in;
  set_job_t         w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_go;

  assign w_job_in  = set_job_t'({job_central, job_radius});
  assign job_ready = ~w_full;
  assign w_push    = job_valid & job_ready;
  // Start a job only when nothing is in flight, the result slot is free and SET is not busy
  assign w_go      = (r_state == ST_IDLE) & ~w_empty & ~res_valid & ~set_busy;
  assign idle      = (w_count == CNT_W'(0)) & (r_state == ST_IDLE) & ~res_valid;

  set_job_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (JOB_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_go),
    .wdata (w_job_in),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

`ifdef SET_DISP_TIMEOUT_EN
  logic [WDOG_W-1:0] r_wdog;
  logic              r_err_timeout;
  assign err_timeout = r_err_timeout;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^WDOG_W'(TMO_CYC);
  assign err_timeout  = 1'b0;
`endif

  // Dispatch FSM with registered SET request and result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_tag         <= '0;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
`ifdef SET_DISP_TIMEOUT_EN
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state     <= ST_ISSUE;
            set_en      <= 1'b1;
            set_central <= {w_head.x1, w_head.y1, w_head.x2, w_head.y2};
            set_radius  <= {w_head.r1, w_head.r2};
          end
        end
        ST_ISSUE: begin
          set_en  <= 1'b0;
          r_state <= ST_WAIT;
`ifdef SET_DISP_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        ST_WAIT: begin
          if (set_valid) begin
            res_candidate <= set_candidate;
            res_tag       <= r_tag;
            res_valid     <= 1'b1;
            r_tag         <= r_tag + TAG_W'(1);
            r_state       <= ST_IDLE;
`ifdef SET_DISP_TIMEOUT_EN
          end else if (r_wdog == WDOG_W'(TMO_CYC - 1)) begin
            res_candidate <= CAND_TMO;
            res_tag       <= r_tag;
            res_valid     <= 1'b1;
            r_tag         <= r_tag + TAG_W'(1);
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
`endif
          end
        end
        default: begin
          set_en  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_job_dispatcher.sv
// Directed bench for set_job_dispatcher with a behavioural SET core model.
module tb_set_job_dispatcher;

  localparam int unsigned TAG_W = 4;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_central;
  logic [7:0]  job_radius;
  logic        set_en;
  logic [15:0] set_central;
  logic [7:0]  set_radius;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
  logic [TAG_W-1:0] res_tag;
  logic        idle;
  logic        err_timeout;

  // SET model controls and observations
  int          m_lat;
  bit          m_fixed;
  logic [7:0]  m_cand;
  logic [7:0]  pend_cand;
  int          m_cnt;
  bit          m_busy;
  bit          hold_busy;
  int          en_count;
  int          busy_viol;
  logic [15:0] last_c;
  logic [7:0]  last_r;

  int n_chk;
  int n_err;
  int e0;

  assign set_busy = m_busy | hold_busy;

  set_job_dispatcher #(
    .DEPTH   (4),
    .TAG_W   (TAG_W),
    .TMO_CYC (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_central   (job_central),
    .job_radius    (job_radius),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_candidate (res_candidate),
    .res_tag       (res_tag),
    .idle          (idle),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural SET: latches the job on set_en, answers after m_lat cycles (0 = never)
  initial begin
    set_valid = 1'b0; set_candidate = '0; m_cnt = 0; m_busy = 0;
    en_count = 0; busy_viol = 0; last_c = '0; last_r = '0; pend_cand = '0;
    forever begin
      @(negedge clk);
      set_valid = 1'b0;
      if (!rst) begin
        m_cnt = 0; m_busy = 0;
      end else begin
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            set_valid = 1'b1; set_candidate = pend_cand; m_busy = 0;
          end
        end
        if (set_en) begin
          if (set_busy) busy_viol++;
          en_count++;
          last_c = set_central; last_r = set_radius;
          pend_cand = m_fixed ? m_cand : set_radius;
          if (m_lat > 0) begin m_cnt = m_lat; m_busy = 1; end
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b0; job_valid = 1'b0; res_ready = 1'b0; hold_busy = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Offer one job and return at the negedge after it was accepted
  task automatic push(input logic [15:0] c, input logic [7:0] r);
    int n;
    n = 0;
    job_central = c; job_radius = r; job_valid = 1'b1;
    while (!job_ready && n < 300) begin @(negedge clk); n++; end
    chk("push_accept", 32'(job_ready), 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  // Wait for a result, check it, then consume it with a one-cycle ready
  task automatic collect(input string t, input logic [7:0] ec, input logic [TAG_W-1:0] et);
    int n;
    n = 0;
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    chk({t, "_valid"}, 32'(res_valid), 32'd1);
    chk({t, "_cand"}, 32'(res_candidate), 32'(ec));
    chk({t, "_tag"}, 32'(res_tag), 32'(et));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({t, "_clr"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_lat = 40; m_fixed = 1; m_cand = 8'd13; hold_busy = 0;
    job_valid = 0; job_central = '0; job_radius = '0; res_ready = 0; rst = 1'b0;
    @(negedge clk);

    // Reset values
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_set_en", 32'(set_en), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_outputs", {set_central, set_radius}, 32'd0);
    chk("rst_res", {res_candidate, 4'(res_tag), 3'd0, err_timeout}, 32'd0);
    apply_reset();

    // Single job, SET answers 13 after 40 cycles
    e0 = en_count;
    push(16'h4455, 8'h33);
    collect("single", 8'd13, TAG_W'(0));
    chk("single_en_cnt", 32'(en_count - e0), 32'd1);
    chk("single_central", 32'(last_c), 32'h4455);
    chk("single_radius", 32'(last_r), 32'h33);

    // Back-to-back: fill FIFO while SET is busy, fifth push stalls
    apply_reset();
    m_lat = 3; m_fixed = 0; hold_busy = 1;
    e0 = en_count;
    for (int i = 0; i < 4; i++) push(16'(i * 16'h1111), 8'(8'h10 + i));
    chk("b2b_full", 32'(job_ready), 32'd0);
    job_central = 16'h4444; job_radius = 8'h14; job_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("b2b_stall", 32'(job_ready), 32'd0);
    chk("b2b_no_issue", 32'(en_count - e0), 32'd0);
    hold_busy = 0;
    begin
      int n;
      n = 0;
      while (!job_ready && n < 50) begin @(negedge clk); n++; end
      chk("b2b_fifth_accept", 32'(job_ready), 32'd1);
      @(negedge clk);
      job_valid = 1'b0;
    end
    // Result backpressure on the first result
    begin
      int n;
      n = 0;
      while (!res_valid && n < 100) begin @(negedge clk); n++; end
    end
    chk("bp_first_valid", 32'(res_valid), 32'd1);
    repeat (20) @(negedge clk);
    chk("bp_hold_valid", 32'(res_valid), 32'd1);
    chk("bp_hold_cand", 32'(res_candidate), 32'h10);
    chk("bp_no_second_en", 32'(en_count - e0), 32'd1);
    collect("bp_first", 8'h10, TAG_W'(0));
    for (int i = 1; i < 5; i++) collect("b2b", 8'(8'h10 + i), TAG_W'(i));
    chk("b2b_en_total", 32'(en_count - e0), 32'd5);
    chk("b2b_idle", 32'(idle), 32'd1);

    // Tag wrap over 17 jobs
    apply_reset();
    m_lat = 2; m_fixed = 0;
    for (int i = 0; i < 17; i++) begin
      push(16'(i), 8'(i + 1));
      collect("wrap", 8'(i + 1), TAG_W'(i));
    end
    chk("wrap_tag17_zero", 32'(res_tag), 32'd0);

    // Early exit: valid the cycle right after ISSUE, candidate 0
    m_lat = 1; m_fixed = 1; m_cand = 8'd0;
    push(16'hABCD, 8'h77);
    collect("early", 8'd0, TAG_W'(1));
    chk("early_idle", 32'(idle), 32'd1);

    // Asynchronous reset in the middle of WAIT with jobs queued
    m_lat = 40; m_fixed = 0;
    push(16'h1111, 8'h21);
    push(16'h2222, 8'h22);
    push(16'h3333, 8'h23);
    repeat (3) @(negedge clk);
    chk("midwait_busy", 32'(idle), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_idle", 32'(idle), 32'd1);
    chk("midrst_ready", 32'(job_ready), 32'd1);
    chk("midrst_outs", {set_en, res_valid, 2'(0), 4'(res_tag), set_radius, res_candidate}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    e0 = en_count;
    repeat (60) @(negedge clk);
    chk("midrst_jobs_lost", 32'(en_count - e0), 32'd0);
    chk("midrst_no_result", 32'(res_valid), 32'd0);
    chk("midrst_idle_after", 32'(idle), 32'd1);

`ifdef SET_DISP_TIMEOUT_EN
    // SET never answers the first job: timeout code, then the next job proceeds
    apply_reset();
    m_lat = 0; m_fixed = 0;
    push(16'h1234, 8'h21);
    repeat (3) @(negedge clk);
    m_lat = 3;
    push(16'h5678, 8'h42);
    collect("tmo", 8'hFF, TAG_W'(0));
    chk("tmo_err", 32'(err_timeout), 32'd1);
    collect("tmo_next", 8'h42, TAG_W'(1));
    chk("tmo_err_sticky", 32'(err_timeout), 32'd1);
`else
    chk("no_tmo_err", 32'(err_timeout), 32'd0);
`endif

    chk("en_while_busy", 32'(busy_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
